// File: rtl/vector_reg_file.sv
// Vector register file: two combinational read ports, one masked write port and a
// pending-write scoreboard. Define VRF_BYPASS_EN for same-cycle write-through reads.
module vector_reg_file #(
  parameter int DATA_WIDTH   = 19,
  parameter int LANES        = 8,
  parameter int REGNUM       = 16,
  parameter int ADDRESSWIDTH = 4,
  parameter int CNTWIDTH     = $clog2(REGNUM + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDRESSWIDTH-1:0]       ra1,
  input  logic [ADDRESSWIDTH-1:0]       ra2,
  output logic [LANES*DATA_WIDTH-1:0]   rd1,
  output logic [LANES*DATA_WIDTH-1:0]   rd2,
  input  logic                          we3,
  input  logic [ADDRESSWIDTH-1:0]       wa3,
  input  logic [LANES*DATA_WIDTH-1:0]   wd3,
  input  logic [LANES-1:0]              wmask3,
  input  logic                          iss_valid,
  input  logic [ADDRESSWIDTH-1:0]       iss_rd,
  output logic                          iss_ok,
  output logic                          busy1,
  output logic                          busy2,
  output logic [CNTWIDTH-1:0]           pend_cnt
);

  localparam int VW = LANES * DATA_WIDTH;
`ifdef VRF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef logic [VW-1:0] vec_t;

  vec_t                mem_q [REGNUM];
  vec_t                mem_d [REGNUM];
  logic [REGNUM-1:0]   pending_q;
  logic [REGNUM-1:0]   pending_d;
  logic [CNTWIDTH-1:0] pend_cnt_q;
  logic [CNTWIDTH-1:0] pend_cnt_d;

  logic wr_ok_s;
  logic iss_in_range_s;
  logic iss_ok_s;
  logic set_en_s;
  logic inc_s;
  logic dec_s;
  vec_t wr_bitmask_s;
  vec_t wr_merged_s;

  function automatic logic addr_ok(input logic [ADDRESSWIDTH-1:0] a);
    return 32'(a) < 32'(REGNUM);
  endfunction

  function automatic vec_t expand_mask(input logic [LANES-1:0] m);
    vec_t v;
    for (int l = 0; l < LANES; l++) begin
      v[l*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{m[l]}};
    end
    return v;
  endfunction

  // Out-of-range reads give zero; a matching in-flight write is merged lane-wise when bypassing.
  function automatic vec_t read_vec(input logic [ADDRESSWIDTH-1:0] ra, input vec_t stored,
                                    input logic wr_ok, input logic [ADDRESSWIDTH-1:0] wa,
                                    input vec_t wd, input vec_t bm);
    vec_t v;
    v = addr_ok(ra) ? stored : '0;
    if (BYPASS && wr_ok && (wa == ra)) begin
      v = (v & ~bm) | (wd & bm);
    end else begin
      v = v;
    end
    return v;
  endfunction

  always_comb begin
    wr_ok_s        = we3 && addr_ok(wa3);
    iss_in_range_s = addr_ok(iss_rd);
    iss_ok_s       = iss_in_range_s ? (!pending_q[iss_rd] || (wr_ok_s && (wa3 == iss_rd))) : 1'b1;
    set_en_s       = iss_valid && iss_ok_s && iss_in_range_s;
    wr_bitmask_s   = expand_mask(wmask3);
    wr_merged_s    = (mem_q[wa3] & ~wr_bitmask_s) | (wd3 & wr_bitmask_s);

    for (int r = 0; r < REGNUM; r++) begin
      mem_d[r] = (wr_ok_s && (wa3 == ADDRESSWIDTH'(r))) ? wr_merged_s : mem_q[r];
    end

    // Clear first, then set, so a same-register set+clear leaves the bit owned by the new writer.
    pending_d = pending_q;
    if (wr_ok_s) begin
      pending_d[wa3] = 1'b0;
    end else begin
      pending_d = pending_d;
    end
    if (set_en_s) begin
      pending_d[iss_rd] = 1'b1;
    end else begin
      pending_d = pending_d;
    end

    inc_s      = set_en_s && !pending_q[iss_rd];
    dec_s      = wr_ok_s && pending_q[wa3] && !(set_en_s && (iss_rd == wa3));
    pend_cnt_d = pend_cnt_q + CNTWIDTH'(inc_s) - CNTWIDTH'(dec_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REGNUM; r++) begin
        mem_q[r] <= '0;
      end
      pending_q  <= '0;
      pend_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      pending_q  <= pending_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  always_comb begin
    rd1      = read_vec(ra1, mem_q[ra1], wr_ok_s, wa3, wd3, wr_bitmask_s);
    rd2      = read_vec(ra2, mem_q[ra2], wr_ok_s, wa3, wd3, wr_bitmask_s);
    busy1    = addr_ok(ra1) && pending_q[ra1] && !(BYPASS && wr_ok_s && (wa3 == ra1));
    busy2    = addr_ok(ra2) && pending_q[ra2] && !(BYPASS && wr_ok_s && (wa3 == ra2));
    iss_ok   = iss_ok_s;
    pend_cnt = pend_cnt_q;
  end

endmodule

// File: tb/tb_vector_reg_file.sv
// Directed bench for vector_reg_file with a behavioural model feeding an expectation queue.
module tb_vector_reg_file;

  localparam int DW = 19;
  localparam int NL = 8;
  localparam int VW = DW * NL;
`ifdef VRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, we3, iss_valid;
  logic [3:0]    ra1, ra2, wa3, iss_rd;
  logic [VW-1:0] rd1, rd2, wd3;
  logic [NL-1:0] wmask3;
  logic          iss_ok, busy1, busy2;
  logic [4:0]    pend_cnt;

  vector_reg_file dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we3(we3), .wa3(wa3), .wd3(wd3), .wmask3(wmask3),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ok(iss_ok),
    .busy1(busy1), .busy2(busy2), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  logic [VW-1:0] m_mem [16];
  logic [15:0]   m_pend;
  logic [VW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  function automatic logic [VW-1:0] m_rd(input logic [3:0] ra);
    logic [VW-1:0] v;
    v = m_mem[ra];
    if (BYP && we3 && wa3 == ra)
      for (int l = 0; l < NL; l++)
        if (wmask3[l]) v[l*DW +: DW] = wd3[l*DW +: DW];
    return v;
  endfunction

  function automatic logic m_busy(input logic [3:0] ra);
    return m_pend[ra] && !(BYP && we3 && wa3 == ra);
  endfunction

  function automatic logic m_iss_ok();
    return !m_pend[iss_rd] || (we3 && wa3 == iss_rd);
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] obs);
    logic [VW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic chk_const(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] e);
    exp_q.push_back(e);
    chk(tag, obs);
  endtask

  task automatic check_all(input string tag);
    #1;
    exp_q.push_back(m_rd(ra1));
    exp_q.push_back(m_rd(ra2));
    exp_q.push_back(VW'(m_busy(ra1)));
    exp_q.push_back(VW'(m_busy(ra2)));
    exp_q.push_back(VW'(m_iss_ok()));
    exp_q.push_back(VW'($countones(m_pend)));
    chk({tag, ".rd1"}, rd1);
    chk({tag, ".rd2"}, rd2);
    chk({tag, ".busy1"}, VW'(busy1));
    chk({tag, ".busy2"}, VW'(busy2));
    chk({tag, ".iss_ok"}, VW'(iss_ok));
    chk({tag, ".pend_cnt"}, VW'(pend_cnt));
  endtask

  // Advance the model with the inputs present at the coming edge, then cross it.
  task automatic tick();
    logic ok;
    ok = m_iss_ok();
    if (rst) begin
      for (int r = 0; r < 16; r++) m_mem[r] = '0;
      m_pend = '0;
    end else begin
      if (we3) begin
        for (int l = 0; l < NL; l++)
          if (wmask3[l]) m_mem[wa3][l*DW +: DW] = wd3[l*DW +: DW];
        m_pend[wa3] = 1'b0;
      end
      if (iss_valid && ok) m_pend[iss_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we3 = 1'b0; iss_valid = 1'b0; wmask3 = '0; wd3 = '0; wa3 = '0;
  endtask

  logic [VW-1:0] v5, v_all;

  initial begin
    for (int r = 0; r < 16; r++) m_mem[r] = {VW{1'b1}};
    m_pend = '1;
    rst = 1'b1; ra1 = '0; ra2 = '0; iss_rd = '0;
    idle();
    tick();
    rst = 1'b0;

    for (int r = 0; r < 16; r++) begin
      ra1 = 4'(r); ra2 = 4'(15 - r); iss_rd = 4'(r);
      check_all("reset_scan");
    end
    chk_const("reset_rd1_zero", rd1, '0);

    for (int l = 0; l < NL; l++) v5[l*DW +: DW] = DW'(l + 1);
    we3 = 1'b1; wa3 = 4'd5; wd3 = v5; wmask3 = 8'hFF; ra1 = 4'd5; ra2 = 4'd5;
    check_all("wr5_full_pre");
    tick();
    idle();
    check_all("wr5_full_post");
    chk_const("wr5_full_const", rd1, v5);
    v_all = {NL{19'h7FFFF}};
    we3 = 1'b1; wa3 = 4'd5; wd3 = v_all; wmask3 = 8'h0F;
    tick();
    idle();
    check_all("wr5_mask");
    chk_const("wr5_mask_const", rd1, {v5[VW-1:4*DW], v_all[4*DW-1:0]});

    iss_valid = 1'b1; iss_rd = 4'd3; ra1 = 4'd3;
    check_all("iss3");
    tick();
    iss_valid = 1'b0;
    check_all("iss3_after");
    chk_const("busy1_reg3", VW'(busy1), VW'(1));
    iss_valid = 1'b1;
    check_all("reiss3_blocked");
    chk_const("iss_ok_blocked", VW'(iss_ok), VW'(0));
    tick();
    check_all("reiss3_nochange");
    we3 = 1'b1; wa3 = 4'd3; wmask3 = 8'h00;
    check_all("wb3_reiss");
    chk_const("iss_ok_wb_free", VW'(iss_ok), VW'(1));
    tick();
    idle();
    check_all("wb3_reiss_after");
    chk_const("cnt_after_reiss", VW'(pend_cnt), VW'(1));
    we3 = 1'b1; wa3 = 4'd3;
    tick();
    idle();
    check_all("clear3");

    for (int r = 0; r < 16; r++) begin
      iss_valid = 1'b1; iss_rd = 4'(r);
      tick();
    end
    idle();
    check_all("all_pending");
    chk_const("cnt_16", VW'(pend_cnt), VW'(16));
    for (int r = 0; r < 16; r++) begin
      we3 = 1'b1; wa3 = 4'(r); wmask3 = 8'h00;
      tick();
    end
    idle();
    check_all("all_cleared");
    chk_const("cnt_0", VW'(pend_cnt), VW'(0));
    iss_valid = 1'b1; iss_rd = 4'd7;
    tick();
    iss_valid = 1'b1; iss_rd = 4'd2; we3 = 1'b1; wa3 = 4'd7; ra1 = 4'd2; ra2 = 4'd7;
    tick();
    idle();
    check_all("set2_clr7");
    chk_const("cnt_set_clr", VW'(pend_cnt), VW'(1));
    we3 = 1'b1; wa3 = 4'd2;
    tick();
    idle();

    iss_valid = 1'b1; iss_rd = 4'd9;
    tick();
    idle();
    ra1 = 4'd9; ra2 = 4'd5;
    we3 = 1'b1; wa3 = 4'd9; wmask3 = 8'h01;
    wd3 = {NL{19'h55}}; wd3[DW-1:0] = 19'h123;
    check_all("bypass_same_cycle");
    chk_const("bypass_lane0", VW'(rd1[DW-1:0]), BYP ? VW'(19'h123) : VW'(0));
    chk_const("bypass_busy1", VW'(busy1), BYP ? VW'(0) : VW'(1));
    tick();
    idle();
    check_all("bypass_next");
    chk_const("wr9_lane0", VW'(rd1[DW-1:0]), VW'(19'h123));

    we3 = 1'b1; wa3 = 4'd1; wd3 = v5; wmask3 = 8'hFF;
    tick();
    idle();
    for (int r = 10; r < 14; r++) begin
      iss_valid = 1'b1; iss_rd = 4'(r);
      tick();
    end
    idle();
    ra1 = 4'd1; ra2 = 4'd10; iss_rd = 4'd11;
    check_all("pre_reset");
    chk_const("cnt_4", VW'(pend_cnt), VW'(4));
    rst = 1'b1; we3 = 1'b1; wa3 = 4'd1; wd3 = v_all; wmask3 = 8'hFF;
    iss_valid = 1'b1; iss_rd = 4'd12;
    tick();
    rst = 1'b0;
    idle();
    check_all("post_reset");
    chk_const("reg1_zero", rd1, '0);
    chk_const("cnt_zero", VW'(pend_cnt), VW'(0));
    chk_const("busy2_zero", VW'(busy2), VW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
